// File: rtl/e203_exu_alu_dpath_arb.sv
// Shares one adder/comparator datapath between the BJP, AGU and MDV requesters through a one-entry issue stage.
// Defining E203_ALU_ARB_RR_EN selects round-robin priority; otherwise priority is fixed r0 > r1 > r2.
module e203_exu_alu_dpath_arb #(
   parameter int XLEN = 32,
   parameter int OPW  = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            r0_valid,
   output logic            r0_ready,
   input  logic            r0_lock,
   input  logic [XLEN-1:0] r0_op1,
   input  logic [XLEN-1:0] r0_op2,
   input  logic [OPW-1:0]  r0_op,
   input  logic            r1_valid,
   output logic            r1_ready,
   input  logic            r1_lock,
   input  logic [XLEN-1:0] r1_op1,
   input  logic [XLEN-1:0] r1_op2,
   input  logic [OPW-1:0]  r1_op,
   input  logic            r2_valid,
   output logic            r2_ready,
   input  logic            r2_lock,
   input  logic [XLEN-1:0] r2_op1,
   input  logic [XLEN-1:0] r2_op2,
   input  logic [OPW-1:0]  r2_op,
   output logic [XLEN-1:0] dp_op1,
   output logic [XLEN-1:0] dp_op2,
   output logic [OPW-1:0]  dp_op,
   input  logic [XLEN-1:0] dp_add_res,
   input  logic            dp_cmp_res,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [1:0]      rsp_id,
   output logic [XLEN-1:0] rsp_add_res,
   output logic            rsp_cmp_res,
   output logic            rsp_err
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state;
   logic [1:0]      owner;
   logic            stage_valid;
   logic [XLEN-1:0] stage_op1;
   logic [XLEN-1:0] stage_op2;
   logic [OPW-1:0]  stage_op;
   logic [1:0]      stage_id;
   logic            stage_err;

   logic            accept_en;
   logic [1:0]      start;
   logic [2:0]      grant_vec;
   logic [1:0]      grant_id;
   logic [XLEN-1:0] sel_op1;
   logic [XLEN-1:0] sel_op2;
   logic [OPW-1:0]  sel_op;
   logic            sel_lock;
   logic            sel_err;

`ifdef E203_ALU_ARB_RR_EN
   logic [1:0] last_grant;
   assign start = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
`else
   assign start = 2'd0;
`endif

   assign accept_en = ~stage_valid | rsp_ready;

   // Ready is gated by rst so that all handshakes vanish the moment reset asserts.
   always_comb begin
      grant_vec = 3'b000;
      if (accept_en && !rst) begin
         if (state == LOCKED) begin
            case (owner)
               2'd0:    grant_vec[0] = r0_valid;
               2'd1:    grant_vec[1] = r1_valid;
               default: grant_vec[2] = r2_valid;
            endcase
         end else begin
            case (start)
               2'd1: begin
                  if (r1_valid)      grant_vec[1] = 1'b1;
                  else if (r2_valid) grant_vec[2] = 1'b1;
                  else if (r0_valid) grant_vec[0] = 1'b1;
               end
               2'd2: begin
                  if (r2_valid)      grant_vec[2] = 1'b1;
                  else if (r0_valid) grant_vec[0] = 1'b1;
                  else if (r1_valid) grant_vec[1] = 1'b1;
               end
               default: begin
                  if (r0_valid)      grant_vec[0] = 1'b1;
                  else if (r1_valid) grant_vec[1] = 1'b1;
                  else if (r2_valid) grant_vec[2] = 1'b1;
               end
            endcase
         end
      end
   end

   assign grant_id = grant_vec[2] ? 2'd2 : (grant_vec[1] ? 2'd1 : 2'd0);

   always_comb begin
      sel_op1  = r0_op1;
      sel_op2  = r0_op2;
      sel_op   = r0_op;
      sel_lock = r0_lock;
      case (grant_id)
         2'd1: begin
            sel_op1 = r1_op1; sel_op2 = r1_op2; sel_op = r1_op; sel_lock = r1_lock;
         end
         2'd2: begin
            sel_op1 = r2_op1; sel_op2 = r2_op2; sel_op = r2_op; sel_lock = r2_lock;
         end
         default: ;
      endcase
   end

   // All-zero ops count as malformed too.
   assign sel_err = ($countones(sel_op) != 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= 2'd0;
         stage_valid <= 1'b0;
         stage_op1   <= '0;
         stage_op2   <= '0;
         stage_op    <= '0;
         stage_id    <= 2'd0;
         stage_err   <= 1'b0;
`ifdef E203_ALU_ARB_RR_EN
         last_grant  <= 2'd2;
`endif
      end else if (|grant_vec) begin
         stage_valid <= 1'b1;
         stage_op1   <= sel_op1;
         stage_op2   <= sel_op2;
         stage_op    <= sel_op;
         stage_id    <= grant_id;
         stage_err   <= sel_err;
`ifdef E203_ALU_ARB_RR_EN
         last_grant  <= grant_id;
`endif
         if (state == IDLE && sel_lock) begin
            state <= LOCKED;
            owner <= grant_id;
         end else if (state == LOCKED && !sel_lock) begin
            state <= IDLE;
         end
      end else if (stage_valid && rsp_ready) begin
         stage_valid <= 1'b0;
      end
   end

   assign r0_ready    = grant_vec[0];
   assign r1_ready    = grant_vec[1];
   assign r2_ready    = grant_vec[2];

   // Idle datapath inputs are forced to zero so the adder does not toggle.
   assign dp_op1      = stage_valid ? stage_op1 : '0;
   assign dp_op2      = stage_valid ? stage_op2 : '0;
   assign dp_op       = stage_valid ? stage_op  : '0;

   assign rsp_valid   = stage_valid;
   assign rsp_id      = stage_valid ? stage_id : 2'd0;
   assign rsp_err     = stage_valid & stage_err;
   assign rsp_add_res = dp_add_res;
   assign rsp_cmp_res = dp_cmp_res;

endmodule

// File: tb/tb_e203_exu_alu_dpath_arb.sv
// Directed scenarios followed by random traffic, all checked against a cycle-level reference model of the arbiter.
module tb_e203_exu_alu_dpath_arb;
   localparam int XLEN = 32;
   localparam int OPW  = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic            v   [3];
   logic            lk  [3];
   logic [XLEN-1:0] o1  [3];
   logic [XLEN-1:0] o2  [3];
   logic [OPW-1:0]  opv [3];
   logic            r0_ready, r1_ready, r2_ready;
   logic [2:0]      rdy;
   logic [XLEN-1:0] dp_op1, dp_op2, dp_add_res, rsp_add_res;
   logic [OPW-1:0]  dp_op;
   logic            dp_cmp_res, rsp_valid, rsp_ready, rsp_cmp_res, rsp_err;
   logic [1:0]      rsp_id;

   assign rdy = {r2_ready, r1_ready, r0_ready};

   e203_exu_alu_dpath_arb #(.XLEN(XLEN), .OPW(OPW)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(v[0]), .r0_ready(r0_ready), .r0_lock(lk[0]), .r0_op1(o1[0]), .r0_op2(o2[0]), .r0_op(opv[0]),
      .r1_valid(v[1]), .r1_ready(r1_ready), .r1_lock(lk[1]), .r1_op1(o1[1]), .r1_op2(o2[1]), .r1_op(opv[1]),
      .r2_valid(v[2]), .r2_ready(r2_ready), .r2_lock(lk[2]), .r2_op1(o1[2]), .r2_op2(o2[2]), .r2_op(opv[2]),
      .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_op(dp_op),
      .dp_add_res(dp_add_res), .dp_cmp_res(dp_cmp_res),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_add_res(rsp_add_res), .rsp_cmp_res(rsp_cmp_res), .rsp_err(rsp_err)
   );

   function automatic logic cmp_fn(input logic [OPW-1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      case (op)
         7'h01:   return a == b;
         7'h02:   return a != b;
         7'h04:   return $signed(a) < $signed(b);
         7'h08:   return $signed(a) > $signed(b);
         7'h10:   return a < b;
         7'h20:   return a > b;
         default: return 1'b0;
      endcase
   endfunction

   // Stand-in for the shared adder/comparator.
   assign dp_add_res = dp_op1 + dp_op2;
   assign dp_cmp_res = cmp_fn(dp_op, dp_op1, dp_op2);

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state.
   bit              m_sv, m_err, m_locked;
   int              m_id, m_owner, m_last;
   logic [XLEN-1:0] m_op1, m_op2;
   logic [OPW-1:0]  m_op;
   bit              pend [3];
   int              last_g;

   task automatic model_reset();
      m_sv = 0; m_err = 0; m_locked = 0; m_id = 0; m_owner = 0; m_last = 2;
      for (int n = 0; n < 3; n++) pend[n] = 0;
   endtask

   // Entered just after a negedge with inputs driven; exits at the next negedge.
   task automatic step();
      int g;
      logic [2:0] exp_rdy;
      #1;
      for (int n = 0; n < 3; n++)
         if (pend[n]) assert (v[n]) else $error("requester %0d dropped valid before acceptance", n);
      g = -1;
      if (!m_sv || rsp_ready) begin
         if (m_locked) begin
            if (v[m_owner]) g = m_owner;
         end else begin
`ifdef E203_ALU_ARB_RR_EN
            for (int k = 1; k <= 3; k++) begin
               int c = (m_last + k) % 3;
               if (g < 0 && v[c]) g = c;
            end
`else
            for (int c = 0; c < 3; c++) if (g < 0 && v[c]) g = c;
`endif
         end
      end
      exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
      chk("ready", 64'(rdy), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_sv));
      if (m_sv) begin
         chk("rsp_id", 64'(rsp_id), 64'(m_id));
         chk("rsp_err", 64'(rsp_err), 64'(m_err));
         if (!m_err) begin
            chk("rsp_add", 64'(rsp_add_res), 64'(XLEN'(m_op1 + m_op2)));
            chk("rsp_cmp", 64'(rsp_cmp_res), 64'(cmp_fn(m_op, m_op1, m_op2)));
         end
      end else begin
         chk("dp_idle", 64'(dp_op1 | dp_op2 | XLEN'(dp_op)), 64'd0);
      end
      if (g >= 0) begin
         m_sv = 1; m_id = g; m_op1 = o1[g]; m_op2 = o2[g]; m_op = opv[g];
         m_err = ($countones(opv[g]) != 1);
         m_last = g;
         if (m_locked) m_locked = lk[g];
         else if (lk[g]) begin m_locked = 1; m_owner = g; end
      end else if (m_sv && rsp_ready) begin
         m_sv = 0;
      end
      for (int n = 0; n < 3; n++) pend[n] = v[n] && (g != n);
      last_g = g;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_beat(input int n, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [OPW-1:0] op, input logic lock);
      v[n] = 1'b1; o1[n] = a; o2[n] = b; opv[n] = op; lk[n] = lock;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int n = 0; n < 3; n++) v[n] = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [XLEN-1:0] held_add;
   int              grants [4];
   int              exp_g4 [4];

   initial begin
      for (int n = 0; n < 3; n++) begin
         v[n] = 0; lk[n] = 0; o1[n] = '0; o2[n] = '0; opv[n] = '0;
      end
      rsp_ready = 1'b1;
      model_reset();
      // Ready must stay low during reset even with a requester present.
      v[0] = 1'b1;
      #1;
      chk("rst_ready", 64'(rdy), 64'd0);
      chk("rst_rsp", 64'({rsp_valid, rsp_id, rsp_err}), 64'd0);
      chk("rst_dp", 64'(dp_op1 | dp_op2 | XLEN'(dp_op)), 64'd0);
      v[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // First beat: 5 + 3, response on the following cycle.
      set_beat(0, 32'd5, 32'd3, 7'h40, 1'b0);
      #1 chk("t1_ready", 64'(rdy), 64'b001);
      step(); v[0] = 1'b0;
      #1;
      chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("t1_rsp_id", 64'(rsp_id), 64'd0);
      chk("t1_rsp_add", 64'(rsp_add_res), 64'd8);
      chk("t1_rsp_err", 64'(rsp_err), 64'd0);
      step();

      // Three requesters continuously valid with full throughput.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         for (int n = 0; n < 3; n++)
            if (!v[n]) set_beat(n, $urandom, $urandom, 7'h40, 1'b0);
         step();
         grants[c] = last_g;
         if (last_g >= 0) v[last_g] = 1'b0;
      end
`ifdef E203_ALU_ARB_RR_EN
      exp_g4 = '{0, 1, 2, 0};
`else
      exp_g4 = '{0, 0, 0, 0};
`endif
      for (int c = 0; c < 4; c++) chk($sformatf("t2_grant%0d", c), 64'(grants[c]), 64'(exp_g4[c]));

      // Backpressure: stage holds, no new acceptances, then accept on release.
      do_reset();
      set_beat(1, 32'h1234, 32'h1111, 7'h40, 1'b0);
      step(); v[1] = 1'b0;
      rsp_ready = 1'b0;
      set_beat(0, 32'd7, 32'd9, 7'h01, 1'b0);
      #1 held_add = rsp_add_res;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t3_hold_ready", 64'(rdy), 64'd0);
         chk("t3_hold_add", 64'(rsp_add_res), 64'(held_add));
         chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
         step();
      end
      rsp_ready = 1'b1;
      #1 chk("t3_release_ready", 64'(rdy), 64'b001);
      step(); v[0] = 1'b0;
      step();

      // Lock held by r2 across an idle gap.
      set_beat(2, 32'd10, 32'd20, 7'h40, 1'b1);
      step(); v[2] = 1'b0;
      set_beat(0, 32'd1, 32'd1, 7'h01, 1'b0);
      for (int c = 0; c < 2; c++) begin
         #1 chk("t4_locked_out", 64'(rdy), 64'd0);
         step();
      end
      set_beat(2, 32'd30, 32'd40, 7'h40, 1'b0);
      #1 chk("t4_owner_ready", 64'(rdy), 64'b100);
      step(); v[2] = 1'b0;
      #1 chk("t4_unlock_r0", 64'(rdy), 64'b001);
      step(); v[0] = 1'b0;

      // Malformed op.
      set_beat(1, 32'd4, 32'd4, 7'h03, 1'b0);
      step(); v[1] = 1'b0;
      #1;
      chk("t5_err", 64'(rsp_err), 64'd1);
      chk("t5_id", 64'(rsp_id), 64'd1);
      step();

      // Reset while a locked beat is in flight.
      set_beat(2, 32'd2, 32'd2, 7'h40, 1'b1);
      step(); v[2] = 1'b0;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", 64'(rsp_valid), 64'd0);
      chk("t6_rst_misc", 64'({rsp_id, rsp_err, rdy}), 64'd0);
      chk("t6_rst_dp", 64'(dp_op1 | dp_op2 | XLEN'(dp_op)), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      set_beat(1, 32'd6, 32'd6, 7'h40, 1'b0);
      #1;
      chk("t6_r1_ready", 64'(rdy), 64'b010);
      chk("t6_no_stale", 64'(rsp_valid), 64'd0);
      step(); v[1] = 1'b0;

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         for (int n = 0; n < 3; n++)
            if (!v[n] && ($urandom % 3 == 0))
               set_beat(n, $urandom, ($urandom % 4 == 0) ? o1[n] : $urandom,
                        ($urandom % 8 == 0) ? OPW'($urandom) : OPW'(1 << ($urandom % 7)),
                        ($urandom % 4 == 0));
         rsp_ready = ($urandom % 4 != 0);
         step();
         if (last_g >= 0) v[last_g] = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/e203_exu_alu_dpath_arb.md
Name: e203_exu_alu_dpath_arb

Overview:
- Arbitrates three EXU requesters (r0 = branch/jump unit, r1 = address-generation unit, r2 = multiply/divide unit) for the single shared adder/comparator datapath.
- Registers the granted operands into a one-entry issue stage that drives the datapath.
- Returns the datapath results on a shared response bus tagged with the requester id.
- Supports a lock so a multi-beat requester (AGU AMO sequences, MDV iterations) can hold the datapath across consecutive beats.

Parameters:
- XLEN, 32, operand/result width.
- OPW, 7, one-hot op vector width; bit order {add, gtu, ltu, gt, lt, ne, eq}, eq = bit 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rN_valid  in  1  requester N (N = 0,1,2) presents a beat
- rN_ready  out  1  beat accepted this cycle when rN_valid & rN_ready
- rN_lock  in  1  keep the datapath for requester N after this beat
- rN_op1  in  XLEN  operand 1
- rN_op2  in  XLEN  operand 2
- rN_op  in  OPW  one-hot op select
- dp_op1  out  XLEN  operand 1 to datapath
- dp_op2  out  XLEN  operand 2 to datapath
- dp_op  out  OPW  op select to datapath
- dp_add_res  in  XLEN  datapath sum, combinational from dp_*
- dp_cmp_res  in  1  datapath compare result, combinational from dp_*
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  2  requester id of the response (0..2)
- rsp_add_res  out  XLEN  equals dp_add_res
- rsp_cmp_res  out  1  equals dp_cmp_res
- rsp_err  out  1  the beat's op was not exactly one-hot

Behaviour:
- Reset (async, rst=1):
  - stage_valid=0, state=IDLE, owner=0, last_grant=2 (r0 highest priority).
  - All rN_ready=0, rsp_valid=0, rsp_id=0, rsp_err=0, dp_op1/dp_op2/dp_op=0.
  - Any in-flight beat is dropped; no response is issued for it.
- Issue stage:
  - accept_en = ~stage_valid | (rsp_valid & rsp_ready).
  - At most one rN_ready is high per cycle, and only when accept_en is high.
  - On an accepted beat, capture op1, op2, op, id and err = (op not one-hot, including all-zero) into the stage; set stage_valid=1.
  - If rsp_valid & rsp_ready and no beat is accepted, clear stage_valid.
- Latency and throughput:
  - A beat accepted in cycle N gives rsp_valid in cycle N+1.
  - With rsp_ready held high, throughput is 1 beat/cycle with no bubble.
- Datapath drive:
  - dp_* are driven from the stage registers while stage_valid=1, else all zero (power gating).
  - rsp_* pass dp results through combinationally.
  - While rsp_valid & ~rsp_ready, the stage and dp_* hold stable.
- Requester hold rule: once asserted, a requester keeps valid and its payload stable until accepted (checked by assertion; not enforced by the block).
- State machine:
  - IDLE: grant the winning requester among valid ones. If the accepted beat has lock=1, go to LOCKED with owner=id.
  - LOCKED: only the owner can receive ready; other requesters see ready=0 even when the owner's valid is low. An accepted owner beat with lock=0 returns the FSM to IDLE. The lock is sampled only on accepted beats.
- Priority:
  - Round-robin: search starts at last_grant+1 mod 3.
  - last_grant updates on every accepted beat, including beats accepted in LOCKED.
- Simultaneous accept and drain in the same cycle: the new beat replaces the stage and stage_valid stays 1.
- A beat with rsp_err=1 still completes normally; the datapath result is don't-care.

Optional Feature:
- Macro: E203_ALU_ARB_RR_EN.
- Defined: round-robin priority as above.
- Undefined: fixed priority r0 > r1 > r2; last_grant is not implemented. Locking behaves identically.

Test Plan:
- Reset, then r0 alone with op1=5, op2=3, op=add(0x40): r0_ready=1 in cycle 0; cycle 1 shows rsp_valid=1, rsp_id=0, rsp_add_res=8, rsp_err=0.
- r0, r1, r2 all valid continuously, rsp_ready=1, RR build: grants go 0,1,2,0 on consecutive cycles. Same stimulus with the macro off: r0 every cycle.
- Backpressure: beat accepted, rsp_ready=0 for 3 cycles: rsp_valid and rsp_* stable, all rN_ready=0. When rsp_ready rises, the next beat is accepted in that same cycle.
- Lock: r2 beat with lock=1, then r2 drops valid for 2 cycles while r0 is valid: r0_ready stays 0. Next r2 beat with lock=0 is accepted, then r0 is granted the following cycle.
- op=0x03 (eq|ne) from r1: response has rsp_err=1, rsp_id=1.
- rst pulsed while stage_valid=1 and state=LOCKED: all outputs are 0 immediately; after release, r1 is granted normally with no stale response.
